ula_flags_stage: RTL and testbench
==================================

ULA_FLAGS_STAGE -- requirements
Module: ula_flags_stage

Interface
REQ-001 Parameter WIDTH, default 3, data width of the ALU result captured by the stage.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  ALU result and flags on the inputs are valid this cycle.
REQ-005 in_ready  output  1  stage can accept the ALU result this cycle.
REQ-006 res_in  input  WIDTH  ALU result (RESU).
REQ-007 z_in, c_in, s_in, o_in  input  1 each  ALU flags Zero, Carry, Sign, Overflow.
REQ-008 upd_mask  input  4  per-flag write enable {O,S,C,Z}, bit 0 = Z.
REQ-009 res_q  output  WIDTH  registered result toward writeback.
REQ-010 out_valid  output  1  res_q holds an undelivered result.
REQ-011 out_ready  input  1  writeback consumes res_q this cycle.
REQ-012 flags_q  output  4  architectural flag register {O,S,C,Z}.
REQ-013 cond  input  4  condition code to evaluate.
REQ-014 cond_valid  input  1  condition query request.
REQ-015 taken  output  1  condition result.
REQ-016 taken_valid  output  1  taken is valid this cycle.
REQ-017 sticky_clr  input  1  clear sticky overflow state.
REQ-018 ovf_sticky  output  1  an overflow has been captured since last clear.
REQ-019 ovf_count  output  4  saturating count of captured overflows.

Function
REQ-020 Output buffer SHALL be a one-entry register with states EMPTY and FULL; out_valid = (state == FULL).
REQ-021 in_ready SHALL equal (state == EMPTY) or out_ready, combinationally, and 0 while rst_n = 0.
REQ-022 Capture: in_valid and in_ready at edge SHALL load res_q <= res_in and enter/stay FULL; zero added latency beyond that edge.
REQ-023 EMPTY->FULL on capture; FULL->EMPTY on out_ready without capture; FULL->FULL on out_ready with capture (back-to-back, no bubble); FULL with out_ready = 0 SHALL hold res_q unchanged.
REQ-024 On capture, each flags_q bit i with upd_mask[i] = 1 SHALL take the corresponding input flag; bits with mask 0 SHALL hold; no capture -> flags_q holds.
REQ-025 Condition query at cycle N SHALL produce taken and taken_valid = 1 at cycle N+1, evaluated on flags_q value after edge N (a capture in cycle N is bypassed into the evaluation).
REQ-026 taken_valid SHALL be 0 in any cycle not following a cond_valid cycle; taken SHALL be 0 when taken_valid = 0.
REQ-027 Condition codes: 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 S; 6 !S; 7 O; 8 !O; 9 LT = S^O; 10 GE = !(S^O); 11 LE = Z|(S^O); 12 GT = !Z & !(S^O); 13 HI = C & !Z; 14 LS = !C | Z; 15 never.
REQ-028 Overflow event = capture with o_in = 1 and upd_mask[3] = 1; event SHALL set ovf_sticky and increment ovf_count, saturating at 15 (no wrap).
REQ-029 sticky_clr alone SHALL clear ovf_sticky and ovf_count next edge; sticky_clr with simultaneous event SHALL yield ovf_sticky = 1, ovf_count = 1.
REQ-030 out_ready while EMPTY SHALL be ignored; in_valid while in_ready = 0 SHALL not alter any state.

Reset
REQ-031 rst_n = 0 at an edge SHALL force state EMPTY, res_q = 0, flags_q = 0000, taken = 0, taken_valid = 0, ovf_sticky = 0, ovf_count = 0, overriding any simultaneous capture, query or clear.
REQ-032 Reset mid-operation SHALL discard a held FULL result with no delivery; first capture allowed at first edge with rst_n = 1.

Verification
REQ-033 Capture res_in=000, flags Z=1,C=1,S=0,O=0, mask 1111, out_ready=1 -> next cycle res_q=000, out_valid=1, flags_q=0011.
REQ-034 Hold out_ready=0, present two results 011 then 101 -> res_q stays 011, in_ready=0, second accepted only on the out_ready=1 cycle, no loss.
REQ-035 Capture O=1,S=1 with mask 1111 and cond=9 same cycle -> next cycle taken_valid=1, taken=0 (bypass: S^O=0); cond=7 -> taken=1.
REQ-036 Capture with mask 0001, z_in=1, prior flags_q=1110 -> flags_q=1111; mask 0000 -> unchanged.
REQ-037 17 overflow captures -> ovf_count=15, ovf_sticky=1; sticky_clr with simultaneous overflow -> ovf_count=1, ovf_sticky=1.
REQ-038 rst_n=0 while FULL and cond_valid=1 -> next cycle all outputs 0, out_valid=0, taken_valid=0.

Source files
------------

// File: rtl/ula_flags_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ula_flags_stage_if
// Brief    : Handshake, result, flag, condition-query and overflow bundle of
//            the ALU flags stage.
// Revision : 1.0
// ============================================================================
interface ula_flags_stage_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res_in;
    logic             z_in;
    logic             c_in;
    logic             s_in;
    logic             o_in;
    logic [3:0]       upd_mask;
    logic [WIDTH-1:0] res_q;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       flags_q;
    logic [3:0]       cond;
    logic             cond_valid;
    logic             taken;
    logic             taken_valid;
    logic             sticky_clr;
    logic             ovf_sticky;
    logic [3:0]       ovf_count;

    modport master (
        output in_valid, res_in, z_in, c_in, s_in, o_in, upd_mask,
        output out_ready, cond, cond_valid, sticky_clr,
        input  in_ready, res_q, out_valid, flags_q, taken, taken_valid,
        input  ovf_sticky, ovf_count
    );

    modport slave (
        input  in_valid, res_in, z_in, c_in, s_in, o_in, upd_mask,
        input  out_ready, cond, cond_valid, sticky_clr,
        output in_ready, res_q, out_valid, flags_q, taken, taken_valid,
        output ovf_sticky, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/ula_flags_stage.sv
`default_nettype none
// ============================================================================
// Module   : ula_flags_stage
// Brief    : One-entry ALU result buffer with masked flag register, condition
//            evaluation and sticky/saturating overflow tracking.
// Revision : 1.0
// ============================================================================
module ula_flags_stage #(
    parameter int WIDTH = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ula_flags_stage_if.slave bus
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [3:0] c_cnt_max = 4'hF;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_res;
    logic [3:0]       r_flags;
    logic [3:0]       w_flags_in;
    logic [3:0]       w_flags_next;
    logic             r_taken;
    logic             r_taken_valid;
    logic             w_cond_true;
    logic             r_ovf_sticky;
    logic [3:0]       r_ovf_count;
    logic [3:0]       w_ovf_inc;
    logic             w_ready;
    logic             w_capture;
    logic             w_ovf_event;
    logic             w_z, w_c, w_s, w_o;

    assign w_ready     = rst_n && ((r_state == ST_EMPTY) || bus.out_ready);
    assign w_capture   = bus.in_valid && w_ready;
    assign w_ovf_event = w_capture && bus.o_in && bus.upd_mask[3];

    assign w_flags_in   = {bus.o_in, bus.s_in, bus.c_in, bus.z_in};
    assign w_flags_next = w_capture ? ((w_flags_in & bus.upd_mask) | (r_flags & ~bus.upd_mask))
                                    : r_flags;
    assign w_ovf_inc    = (r_ovf_count == c_cnt_max) ? c_cnt_max : r_ovf_count + 4'd1;

    // Condition sees this cycle's capture so a query right behind an ALU op is exact.
    assign {w_o, w_s, w_c, w_z} = w_flags_next;

    always_comb begin
        w_cond_true = 1'b0;
        case (bus.cond)
            4'd0:    w_cond_true = 1'b1;
            4'd1:    w_cond_true = w_z;
            4'd2:    w_cond_true = !w_z;
            4'd3:    w_cond_true = w_c;
            4'd4:    w_cond_true = !w_c;
            4'd5:    w_cond_true = w_s;
            4'd6:    w_cond_true = !w_s;
            4'd7:    w_cond_true = w_o;
            4'd8:    w_cond_true = !w_o;
            4'd9:    w_cond_true = w_s ^ w_o;
            4'd10:   w_cond_true = !(w_s ^ w_o);
            4'd11:   w_cond_true = w_z || (w_s ^ w_o);
            4'd12:   w_cond_true = !w_z && !(w_s ^ w_o);
            4'd13:   w_cond_true = w_c && !w_z;
            4'd14:   w_cond_true = !w_c || w_z;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_capture) w_state_next = ST_FULL;
            ST_FULL:  if (bus.out_ready && !w_capture) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_EMPTY;
            r_res         <= '0;
            r_flags       <= 4'b0000;
            r_taken       <= 1'b0;
            r_taken_valid <= 1'b0;
            r_ovf_sticky  <= 1'b0;
            r_ovf_count   <= 4'd0;
        end else begin
            r_state       <= w_state_next;
            r_flags       <= w_flags_next;
            r_taken_valid <= bus.cond_valid;
            r_taken       <= bus.cond_valid && w_cond_true;
            if (w_capture) begin
                r_res <= bus.res_in;
            end
            // A clear coinciding with an overflow restarts the tally at that overflow.
            if (bus.sticky_clr) begin
                r_ovf_sticky <= w_ovf_event;
                r_ovf_count  <= w_ovf_event ? 4'd1 : 4'd0;
            end else if (w_ovf_event) begin
                r_ovf_sticky <= 1'b1;
                r_ovf_count  <= w_ovf_inc;
            end
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.res_q       = r_res;
    assign bus.out_valid   = (r_state == ST_FULL);
    assign bus.flags_q     = r_flags;
    assign bus.taken       = r_taken;
    assign bus.taken_valid = r_taken_valid;
    assign bus.ovf_sticky  = r_ovf_sticky;
    assign bus.ovf_count   = r_ovf_count;
endmodule
`default_nettype wire

// File: tb/tb_ula_flags_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_flags_stage
// Brief    : Directed plus random self-checking bench for ula_flags_stage.
// Revision : 1.0
// ============================================================================
module tb_ula_flags_stage;
    localparam int WIDTH = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Behavioural model state
    bit m_full, m_sticky, m_tv, m_tk;
    bit mz, mc, ms, mo;
    int m_res, m_cnt;

    ula_flags_stage_if #(.WIDTH(WIDTH)) ifc ();

    ula_flags_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_eval(input int code, input bit z, input bit c, input bit s, input bit o);
        bit lt;
        lt = (s != o);
        case (code)
            0:  return 1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return !c;
            5:  return s;
            6:  return !s;
            7:  return o;
            8:  return !o;
            9:  return lt;
            10: return !lt;
            11: return z || lt;
            12: return !z && !lt;
            13: return c && !z;
            14: return !c || z;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input bit iv, input int res, input bit z, input bit c, input bit s,
                         input bit o, input int mask, input bit ordy, input bit cv,
                         input int cnd, input bit clr);
        ifc.in_valid   = iv;
        ifc.res_in     = res[WIDTH-1:0];
        ifc.z_in       = z;
        ifc.c_in       = c;
        ifc.s_in       = s;
        ifc.o_in       = o;
        ifc.upd_mask   = mask[3:0];
        ifc.out_ready  = ordy;
        ifc.cond_valid = cv;
        ifc.cond       = cnd[3:0];
        ifc.sticky_clr = clr;
    endtask

    // Predict, clock once, compare every observable output.
    task automatic cycle();
        bit exp_ready, cap, evt;
        #1;
        exp_ready = rst_n && (!m_full || ifc.out_ready);
        chk("in_ready", ifc.in_ready, exp_ready);
        if (!rst_n) begin
            m_full = 0; m_res = 0; {mo, ms, mc, mz} = 4'b0;
            m_tv = 0; m_tk = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            cap = ifc.in_valid && exp_ready;
            evt = cap && ifc.o_in && ifc.upd_mask[3];
            if (cap) begin
                m_res = ifc.res_in;
                if (ifc.upd_mask[0]) mz = ifc.z_in;
                if (ifc.upd_mask[1]) mc = ifc.c_in;
                if (ifc.upd_mask[2]) ms = ifc.s_in;
                if (ifc.upd_mask[3]) mo = ifc.o_in;
                m_full = 1;
            end else if (ifc.out_ready) begin
                m_full = 0;
            end
            if (ifc.sticky_clr) begin
                m_sticky = evt;
                m_cnt    = evt ? 1 : 0;
            end else if (evt) begin
                m_sticky = 1;
                m_cnt    = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
            end
            m_tv = ifc.cond_valid;
            m_tk = ifc.cond_valid && cond_eval(ifc.cond, mz, mc, ms, mo);
        end
        @(posedge clk);
        #1;
        chk("out_valid",   ifc.out_valid, m_full);
        chk("res_q",       ifc.res_q, m_res);
        chk("flags_q",     ifc.flags_q, {mo, ms, mc, mz});
        chk("taken_valid", ifc.taken_valid, m_tv);
        chk("taken",       ifc.taken, m_tk);
        chk("ovf_sticky",  ifc.ovf_sticky, m_sticky);
        chk("ovf_count",   ifc.ovf_count, m_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 5, 1, 1, 1, 1, 15, 1, 1, 0, 0);
        cycle();
        cycle();
        chk("reset_out_valid", ifc.out_valid, 0);
        chk("reset_flags", ifc.flags_q, 4'b0000);
        chk("reset_in_ready", ifc.in_ready, 0);
        rst_n = 1'b1;

        // Basic capture with full mask
        drive(1, 0, 1, 1, 0, 0, 15, 1, 0, 0, 0);
        cycle();
        chk("cap_res", ifc.res_q, 0);
        chk("cap_valid", ifc.out_valid, 1);
        chk("cap_flags", ifc.flags_q, 4'b0011);

        // Backpressure: 3 held while 5 waits, 5 taken on out_ready
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        chk("bp_hold_res", ifc.res_q, 3);
        chk("bp_in_ready", ifc.in_ready, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
        chk("bp_second_res", ifc.res_q, 5);
        chk("bp_second_valid", ifc.out_valid, 1);

        // Bypass into condition evaluation
        drive(1, 1, 0, 0, 1, 1, 15, 1, 1, 9, 0);
        cycle();
        chk("bypass_lt_valid", ifc.taken_valid, 1);
        chk("bypass_lt_taken", ifc.taken, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
        cycle();
        chk("cond_o_taken", ifc.taken, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
        chk("no_query_tv", ifc.taken_valid, 0);

        // Masked flag updates
        drive(1, 2, 0, 1, 1, 1, 15, 1, 0, 0, 0);
        cycle();
        chk("mask_prior", ifc.flags_q, 4'b1110);
        drive(1, 2, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        cycle();
        chk("mask_z_only", ifc.flags_q, 4'b1111);
        drive(1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
        chk("mask_none", ifc.flags_q, 4'b1111);

        // Overflow saturation and clear-with-event
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cycle();
        chk("clr_count", ifc.ovf_count, 0);
        chk("clr_sticky", ifc.ovf_sticky, 0);
        for (int i = 0; i < 17; i++) begin
            drive(1, i, 0, 0, 0, 1, 15, 1, 0, 0, 0);
            cycle();
        end
        chk("sat_count", ifc.ovf_count, 15);
        chk("sat_sticky", ifc.ovf_sticky, 1);
        drive(1, 6, 0, 0, 0, 1, 15, 1, 0, 0, 1);
        cycle();
        chk("clr_evt_count", ifc.ovf_count, 1);
        chk("clr_evt_sticky", ifc.ovf_sticky, 1);

        // Reset while FULL with a query pending
        drive(1, 7, 1, 1, 1, 1, 15, 0, 1, 0, 0);
        rst_n = 1'b0;
        cycle();
        chk("rst_full_valid", ifc.out_valid, 0);
        chk("rst_full_tv", ifc.taken_valid, 0);
        chk("rst_full_res", ifc.res_q, 0);
        chk("rst_full_cnt", ifc.ovf_count, 0);
        rst_n = 1'b1;
        drive(1, 4, 0, 0, 0, 0, 15, 0, 0, 0, 0);
        cycle();
        chk("post_rst_cap", ifc.res_q, 4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(31) != 0);
            drive($urandom_range(1), $urandom, $urandom_range(1), $urandom_range(1),
                  $urandom_range(1), $urandom_range(1), $urandom_range(15),
                  $urandom_range(1), $urandom_range(1), $urandom_range(15),
                  ($urandom_range(7) == 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
